decode_cycle: RTL and testbench

DECODE_CYCLE -- requirements
Module: decode_cycle

---
 rtl/decode_cycle_pkg.sv | 48 ++++
 rtl/decode_cycle_register_file.sv | 42 ++++
 rtl/decode_cycle.sv | 136 +++++++++++++
 tb/tb_decode_cycle.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_cycle_pkg.sv
// decode_cycle_pkg: opcode constants, ALUOp/ALUControl/ImmSrc encodings and the
// ALU-control decode helper shared by all pipeline stages.
package decode_cycle_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // Subtract is only legal for register-register ops; addi with imm[10]=1
    // shares the funct7[5] bit position and must still add.
    function automatic alu_ctrl_e alu_decode(input alu_op_e op, input logic [2:0] funct3,
                                             input logic funct7_b5, input logic is_r);
        if (op == ALUOP_SUB) return ALU_SUB;
        if (op != ALUOP_FUNCT) return ALU_ADD;
        case (funct3)
            3'b000:  return (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/decode_cycle_register_file.sv
// Register_File: NREG x XLEN register file, two combinational read ports, one write port.
//   clk, rst (async active-low, clears every entry)
//   a1/a2 -> rd1/rd2 : read ports, x0 always reads 0
//   we, a3, wd       : write port, writes to x0 discarded
// Macro RF_WB_BYPASS_EN: a read of the register being written this cycle returns wd.
module Register_File #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      a1,
    input  logic [4:0]      a2,
    input  logic            we,
    input  logic [4:0]      a3,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we && a3 != '0) regs_d[a3] = wd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) regs_q <= '{default: '0};
        else      regs_q <= regs_d;
    end

`ifdef RF_WB_BYPASS_EN
    assign rd1 = (a1 == '0) ? '0 : (we && a3 == a1) ? wd : regs_q[a1];
    assign rd2 = (a2 == '0) ? '0 : (we && a3 == a2) ? wd : regs_q[a2];
`else
    assign rd1 = (a1 == '0) ? '0 : regs_q[a1];
    assign rd2 = (a2 == '0) ? '0 : regs_q[a2];
`endif

endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: RISC-V decode stage plus ID/EX pipeline register.
//   clk, rst (async active-low)
//   Instr_D, PC_D, PCPlusD            : instruction and PCs from IF/ID
//   RegWrite_W, RD_W, Result_W        : write-back port into the register file
//   Stall_D (hold ID/EX), Flush_E (bubble, wins over Stall_D)
//   *_E outputs                       : registered controls, operands, immediate, indices
// Macro RF_WB_BYPASS_EN: same-cycle write-back forwarding inside the register file.
module decode_cycle
    import decode_cycle_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     Instr_D,
    input  logic [XLEN-1:0] PC_D,
    input  logic [XLEN-1:0] PCPlusD,
    input  logic            RegWrite_W,
    input  logic [4:0]      RD_W,
    input  logic [XLEN-1:0] Result_W,
    input  logic            Stall_D,
    input  logic            Flush_E,
    output logic            RegWrite_E,
    output logic            MemWrite_E,
    output logic            ALUSrc_E,
    output logic            Branch_E,
    output logic            Jump_E,
    output logic [1:0]      ResultSrc_E,
    output logic [2:0]      ALUControl_E,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] Imm_Ext_E,
    output logic [XLEN-1:0] PC_E,
    output logic [XLEN-1:0] PCPlus_E,
    output logic [4:0]      RS1_E,
    output logic [4:0]      RS2_E,
    output logic [4:0]      RD_E
);

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            alu_src;
        logic            branch;
        logic            jump;
        logic [1:0]      result_src;
        alu_ctrl_e       alu_ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } idex_t;

    logic [XLEN-1:0] rd1, rd2, imm_i, imm_s, imm_b, imm_j;
    logic [6:0]      op;
    alu_op_e         alu_op;
    imm_src_e        imm_src;
    idex_t           dec, idex_d, idex_q;

    Register_File #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk (clk),
        .rst (rst),
        .a1  (Instr_D[19:15]),
        .a2  (Instr_D[24:20]),
        .we  (RegWrite_W),
        .a3  (RD_W),
        .wd  (Result_W),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    assign op    = Instr_D[6:0];
    assign imm_i = {{(XLEN-12){Instr_D[31]}}, Instr_D[31:20]};
    assign imm_s = {{(XLEN-12){Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};
    assign imm_b = {{(XLEN-12){Instr_D[31]}}, Instr_D[7], Instr_D[30:25], Instr_D[11:8], 1'b0};
    assign imm_j = {{(XLEN-20){Instr_D[31]}}, Instr_D[19:12], Instr_D[20], Instr_D[30:21], 1'b0};

    always_comb begin
        dec     = '0;
        alu_op  = ALUOP_ADD;
        imm_src = IMM_I;
        case (op)
            OP_LW:  begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 2'b01; end
            OP_SW:  begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; imm_src = IMM_S; end
            OP_R:   begin dec.reg_write = 1'b1; alu_op = ALUOP_FUNCT; end
            OP_I:   begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; alu_op = ALUOP_FUNCT; end
            OP_BEQ: begin dec.branch = 1'b1; alu_op = ALUOP_SUB; imm_src = IMM_B; end
            OP_JAL: begin dec.reg_write = 1'b1; dec.jump = 1'b1; dec.result_src = 2'b10; imm_src = IMM_J; end
            default: ;
        endcase
        dec.alu_ctrl = alu_decode(alu_op, Instr_D[14:12], Instr_D[30], op == OP_R);
        dec.imm_ext  = (imm_src == IMM_S) ? imm_s :
                       (imm_src == IMM_B) ? imm_b :
                       (imm_src == IMM_J) ? imm_j : imm_i;
        dec.rd1      = rd1;
        dec.rd2      = rd2;
        dec.pc       = PC_D;
        dec.pc_plus  = PCPlusD;
        dec.rs1      = Instr_D[19:15];
        dec.rs2      = Instr_D[24:20];
        dec.rd       = Instr_D[11:7];
    end

    always_comb begin
        idex_d = dec;
        if (Flush_E)      idex_d = '0;
        else if (Stall_D) idex_d = idex_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idex_q <= '0;
        else      idex_q <= idex_d;
    end

    assign RegWrite_E   = idex_q.reg_write;
    assign MemWrite_E   = idex_q.mem_write;
    assign ALUSrc_E     = idex_q.alu_src;
    assign Branch_E     = idex_q.branch;
    assign Jump_E       = idex_q.jump;
    assign ResultSrc_E  = idex_q.result_src;
    assign ALUControl_E = idex_q.alu_ctrl;
    assign RD1_E        = idex_q.rd1;
    assign RD2_E        = idex_q.rd2;
    assign Imm_Ext_E    = idex_q.imm_ext;
    assign PC_E         = idex_q.pc;
    assign PCPlus_E     = idex_q.pc_plus;
    assign RS1_E        = idex_q.rs1;
    assign RS2_E        = idex_q.rs2;
    assign RD_E         = idex_q.rd;

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: table vectors, hand-written hazard/reset/bypass sequences and
// randomized instructions checked against a behavioural decode/pipeline model.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_d, pc_d, pcplus_d, result_w;
    logic [4:0]  rd_w;
    logic        regwrite_w, stall_d, flush_e;
    logic        regwrite_e, memwrite_e, alusrc_e, branch_e, jump_e;
    logic [1:0]  resultsrc_e;
    logic [2:0]  aluctrl_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pcplus_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk(clk), .rst(rst), .Instr_D(instr_d), .PC_D(pc_d), .PCPlusD(pcplus_d),
        .RegWrite_W(regwrite_w), .RD_W(rd_w), .Result_W(result_w),
        .Stall_D(stall_d), .Flush_E(flush_e),
        .RegWrite_E(regwrite_e), .MemWrite_E(memwrite_e), .ALUSrc_E(alusrc_e),
        .Branch_E(branch_e), .Jump_E(jump_e), .ResultSrc_E(resultsrc_e),
        .ALUControl_E(aluctrl_e), .RD1_E(rd1_e), .RD2_E(rd2_e), .Imm_Ext_E(imm_e),
        .PC_E(pc_e), .PCPlus_E(pcplus_e), .RS1_E(rs1_e), .RS2_E(rs2_e), .RD_E(rd_e)
    );

    typedef struct packed {
        logic        rw, mw, asrc, br, jmp;
        logic [1:0]  rsrc;
        logic [2:0]  ac;
        logic [31:0] rd1, rd2, imm, pc, pcp;
        logic [4:0]  rs1, rs2, rd;
    } stage_t;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  ctrl;
        logic [31:0] imm;
        bit          care;
    } vec_t;

    stage_t      act, exp_s;
    bit          exp_care;
    logic [31:0] regs [32];
    int          tests = 0, fails = 0;

    assign act = {regwrite_e, memwrite_e, alusrc_e, branch_e, jump_e, resultsrc_e, aluctrl_e,
                  rd1_e, rd2_e, imm_e, pc_e, pcplus_e, rs1_e, rs2_e, rd_e};

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef RF_WB_BYPASS_EN
        if (regwrite_w && rd_w == a) return result_w;
`endif
        return regs[a];
    endfunction

    function automatic logic [2:0] alu_model(input logic [2:0] f3, input logic sub_ok);
        case (f3)
            3'd0:    return sub_ok ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic stage_t model(input logic [31:0] i, output bit care);
        stage_t s = '0;
        int imm_i, imm_s, imm_b, imm_j;
        imm_i = $signed(i) >>> 20;
        imm_s = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
        imm_b = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        imm_j = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        s.rs1 = i[19:15]; s.rs2 = i[24:20]; s.rd = i[11:7];
        s.rd1 = rf_read(i[19:15]); s.rd2 = rf_read(i[24:20]);
        s.pc = pc_d; s.pcp = pcplus_d;
        care = 1'b1;
        case (i[6:0])
            7'h03: begin s.rw = 1; s.asrc = 1; s.rsrc = 2'd1; s.imm = 32'(imm_i); end
            7'h23: begin s.mw = 1; s.asrc = 1; s.imm = 32'(imm_s); end
            7'h33: begin s.rw = 1; s.ac = alu_model(i[14:12], i[30]); care = 1'b0; end
            7'h13: begin s.rw = 1; s.asrc = 1; s.ac = alu_model(i[14:12], 1'b0); s.imm = 32'(imm_i); end
            7'h63: begin s.br = 1; s.ac = 3'b001; s.imm = 32'(imm_b); end
            7'h6F: begin s.rw = 1; s.jmp = 1; s.rsrc = 2'd2; s.imm = 32'(imm_j); end
            default: care = 1'b0;
        endcase
        return s;
    endfunction

    function automatic stage_t masked(input stage_t s, input bit care);
        if (!care) s.imm = '0;
        return s;
    endfunction

    task automatic check_stage(input string name);
        tests++;
        if (masked(act, exp_care) !== masked(exp_s, exp_care)) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_s);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (act !== '0) begin
            fails++;
            $display("FAIL %s: got %h expected all zero", name, act);
        end
    endtask

    task automatic step(input logic [31:0] i, input logic rw, input logic [4:0] rd,
                        input logic [31:0] res, input logic st, input logic fl, input string name);
        stage_t nxt;
        bit     nc;
        instr_d = i; regwrite_w = rw; rd_w = rd; result_w = res; stall_d = st; flush_e = fl;
        nxt = model(i, nc);
        if (fl) begin nxt = '0; nc = 1'b1; end
        else if (st) begin nxt = exp_s; nc = exp_care; end
        @(posedge clk);
        if (rw && rd != 5'd0) regs[rd] = res;
        exp_s = nxt; exp_care = nc;
        #1;
        check_stage(name);
        pc_d = pc_d + 1;
        pcplus_d = pc_d + 1;
    endtask

    task automatic do_reset();
        rst = 1'b0; regwrite_w = 1'b0; stall_d = 1'b0; flush_e = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_hold");
        for (int k = 0; k < 32; k++) regs[k] = '0;
        exp_s = '0; exp_care = 1'b1;
        rst = 1'b1;
    endtask

    localparam logic [31:0] NOP = 32'h00000013;

    vec_t        vt [14];
    logic [31:0] i, p;
    logic [6:0]  op;
    int          sel;

    initial begin
        vt = '{
            '{32'h0040A283, 10'b1010001000, 32'd4,        1'b1},
            '{32'h0020A423, 10'b0110000000, 32'd8,        1'b1},
            '{32'hFE000EE3, 10'b0001000001, 32'hFFFFFFFC, 1'b1},
            '{32'h002081B3, 10'b1000000000, 32'd0,        1'b0},
            '{32'h402081B3, 10'b1000000001, 32'd0,        1'b0},
            '{32'h0020F1B3, 10'b1000000010, 32'd0,        1'b0},
            '{32'h0020E1B3, 10'b1000000011, 32'd0,        1'b0},
            '{32'h0020A1B3, 10'b1000000101, 32'd0,        1'b0},
            '{32'hFFF08193, 10'b1010000000, 32'hFFFFFFFF, 1'b1},
            '{32'h40008193, 10'b1010000000, 32'h00000400, 1'b1},
            '{32'h0050A193, 10'b1010000101, 32'd5,        1'b1},
            '{32'h008000EF, 10'b1000110000, 32'd8,        1'b1},
            '{32'hFFFFF0EF, 10'b1000110000, 32'hFFFFFFFE, 1'b1},
            '{32'h0000007F, 10'b0000000000, 32'd0,        1'b1}
        };
        rst = 1'b0; instr_d = NOP; pc_d = 32'd0; pcplus_d = 32'd1;
        regwrite_w = 1'b0; rd_w = '0; result_w = '0; stall_d = 1'b0; flush_e = 1'b0;
        do_reset();

        step(32'h000281B3, 0, 0, 0, 0, 0, "read_x5");
        check_val("x5_after_reset", rd1_e, 32'd0);

        step(NOP, 1, 5'd1, 32'd7, 0, 0, "wr_x1");
        step(NOP, 1, 5'd2, 32'd5, 0, 0, "wr_x2");
        step(32'h002081B3, 0, 0, 0, 0, 0, "add");
        check_val("add_rd1", rd1_e, 32'd7);
        check_val("add_rd2", rd2_e, 32'd5);
        check_val("add_aluctrl", {29'd0, aluctrl_e}, 32'd0);
        check_val("add_regwrite", {31'd0, regwrite_e}, 32'd1);
        check_val("add_rd", {27'd0, rd_e}, 32'd3);

        for (int k = 0; k < 2; k++) begin
            step(32'h0020A423, 1, 5'd6, 32'd11, 1, 0, "stall");
            check_val("stall_rd1", rd1_e, 32'd7);
            check_val("stall_memwrite", {31'd0, memwrite_e}, 32'd0);
            check_val("stall_rd", {27'd0, rd_e}, 32'd3);
        end
        step(32'h000301B3, 0, 0, 0, 0, 0, "rd_x6");
        check_val("wr_during_stall", rd1_e, 32'd11);

        step(32'h002081B3, 0, 0, 0, 1, 1, "stall_flush");
        check_zero("stall_flush_zero");
        step(NOP, 1, 5'd7, 32'd13, 0, 1, "flush_wr");
        check_zero("flush_zero");
        step(32'h000381B3, 0, 0, 0, 0, 0, "rd_x7");
        check_val("wr_during_flush", rd1_e, 32'd13);

        step(NOP, 1, 5'd0, 32'h55, 0, 0, "wr_x0");
        step(32'h000001B3, 0, 0, 0, 0, 0, "rd_x0");
        check_val("x0_rd1", rd1_e, 32'd0);
        check_val("x0_rd2", rd2_e, 32'd0);

        step(NOP, 1, 5'd4, 32'd3, 0, 0, "wr_x4");
        step(32'h00020293, 1, 5'd4, 32'd9, 0, 0, "bypass");
`ifdef RF_WB_BYPASS_EN
        check_val("bypass_rd1", rd1_e, 32'd9);
`else
        check_val("bypass_rd1", rd1_e, 32'd3);
`endif
        step(32'h00020293, 0, 0, 0, 0, 0, "after_bypass");
        check_val("after_bypass_rd1", rd1_e, 32'd9);

        p = pc_d;
        step(32'h0000007F, 0, 0, 0, 0, 0, "unknown");
        check_val("unknown_ctrl", {22'd0, act[184:175]}, 32'd0);
        check_val("unknown_pc", pc_e, p);
        check_val("unknown_pcplus", pcplus_e, p + 1);

        foreach (vt[k]) begin
            step(vt[k].instr, 0, 0, 0, 0, 0, "table");
            check_val("table_ctrl", {22'd0, act[184:175]}, {22'd0, vt[k].ctrl});
            if (vt[k].care) check_val("table_imm", imm_e, vt[k].imm);
        end

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 6);
            i = $urandom;
            op = (sel == 0) ? 7'h03 : (sel == 1) ? 7'h23 : (sel == 2) ? 7'h33 :
                 (sel == 3) ? 7'h13 : (sel == 4) ? 7'h63 : (sel == 5) ? 7'h6F : 7'h7F;
            i[6:0] = op;
            if (op == 7'h33 || op == 7'h13) begin
                sel = $urandom_range(0, 3);
                i[14:12] = (sel == 0) ? 3'd0 : (sel == 1) ? 3'd2 : (sel == 2) ? 3'd6 : 3'd7;
            end
            if (op == 7'h33) i[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            if (op == 7'h63) i[14:12] = 3'd0;
            step(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, "random");
        end

        step(32'h002081B3, 1, 5'd1, 32'd21, 0, 0, "pre_reset");
        #2 rst = 1'b0;
        #1 check_zero("async_reset");
        do_reset();
        step(32'h002081B3, 0, 0, 0, 0, 0, "first_after_reset");
        check_val("post_reset_regwrite", {31'd0, regwrite_e}, 32'd1);
        check_val("post_reset_rd1", rd1_e, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
